// File: rtl/rotate_input.sv
// Debounced two-button rotate input with first-press ownership; one-cycle rotate command per press.
// Optional auto-repeat while held: define ROTATE_AUTOREPEAT_EN.
module rotate_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 371250,
    parameter int unsigned REPEAT_DELAY    = 29700000,
    parameter int unsigned REPEAT_PERIOD   = 11137500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_cw_in,
    input  logic       btn_ccw_in,
    output logic [1:0] rotate_out,
    output logic [1:0] pressed_out
);

    localparam int unsigned DW = 20;

    typedef enum logic [1:0] {
        IDLE,
        HELD_CW,
        HELD_CCW
    } state_t;

    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         prs_q;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    logic [1:0]         rise;
    logic [1:0]         rot_q, rot_d;
    state_t             state_q, state_d;

`ifdef ROTATE_AUTOREPEAT_EN
    logic [25:0] rep_cnt_q, rep_cnt_d;
    logic        rep_first_q, rep_first_d;
    logic        rep_fire;
`endif

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // prs_q doubles as the previous debounced level for rise detection
    assign rise = deb_q & ~prs_q;

`ifdef ROTATE_AUTOREPEAT_EN
    assign rep_fire = (rep_cnt_q + 26'd1) ==
                      (rep_first_q ? 26'(REPEAT_DELAY) : 26'(REPEAT_PERIOD));
`endif

    always_comb begin
        state_d = state_q;
        rot_d   = '0;
`ifdef ROTATE_AUTOREPEAT_EN
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (rise[0] && !deb_q[1]) begin
                    state_d = HELD_CW;
                    rot_d   = 2'b01;
                end else if (rise[1] && !deb_q[0]) begin
                    state_d = HELD_CCW;
                    rot_d   = 2'b10;
                end
            end
            HELD_CW, HELD_CCW: begin
                if (!deb_q[(state_q == HELD_CW) ? 0 : 1]) begin
                    state_d = IDLE;
                end else begin
`ifdef ROTATE_AUTOREPEAT_EN
                    if (rep_fire) begin
                        rot_d       = (state_q == HELD_CW) ? 2'b01 : 2'b10;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d   = rep_cnt_q + 26'd1;
                        rep_first_d = rep_first_q;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            prs_q   <= '0;
            cnt_q   <= '0;
            rot_q   <= '0;
            state_q <= IDLE;
`ifdef ROTATE_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            sync1_q <= {btn_ccw_in, btn_cw_in};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            prs_q   <= deb_q;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            state_q <= state_d;
`ifdef ROTATE_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign rotate_out  = rot_q;
    assign pressed_out = prs_q;

endmodule

// File: tb/tb_rotate_input.sv
// Self-checking bench for rotate_input: per-cycle behavioural model plus directed latency/count checks.
module tb_rotate_input;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cw  = 1'b0;
    logic       ccw = 1'b0;
    logic [1:0] rotate_out;
    logic [1:0] pressed_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int n_cw = 0, n_ccw = 0;
    bit any_prs = 1'b0;

    rotate_input #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_cw_in  (cw),
        .btn_ccw_in (ccw),
        .rotate_out (rotate_out),
        .pressed_out(pressed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw -> two-cycle delayed view, run-length debounce, ownership by first rise.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_prs = '0, m_rot = '0;
    int         m_run [2] = '{0, 0};
    int         m_owner = 0;
    int         m_el = 0;

    always @(posedge clk) begin
        logic [1:0] os1, os2, odeb, oprs, rise;
        os1 = m_s1; os2 = m_s2; odeb = m_deb; oprs = m_prs;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_prs = '0; m_rot = '0;
            m_run[0] = 0; m_run[1] = 0; m_owner = 0; m_el = 0;
        end else begin
            m_s1 = {ccw, cw};
            m_s2 = os1;
            for (int b = 0; b < 2; b++) begin
                if (os2[b] != odeb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_deb[b] = ~odeb[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_prs = odeb;
            m_rot = '0;
            rise  = odeb & ~oprs;
            if (m_owner == 0) begin
                if (rise[0] && !odeb[1]) begin
                    m_owner = 1; m_rot = 2'b01; m_el = 0;
                end else if (rise[1] && !odeb[0]) begin
                    m_owner = 2; m_rot = 2'b10; m_el = 0;
                end
            end else if (!odeb[m_owner-1]) begin
                m_owner = 0;
            end else begin
                m_el++;
`ifdef ROTATE_AUTOREPEAT_EN
                if (m_el == RD || (m_el > RD && (m_el - RD) % RP == 0))
                    m_rot = 2'(m_owner);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rotate_out", int'(rotate_out), int'(m_rot));
            chk("pressed_out", int'(pressed_out), int'(m_prs));
            if (rotate_out == 2'b01) n_cw++;
            if (rotate_out == 2'b10) n_ccw++;
            if (pressed_out != 2'b00) any_prs = 1'b1;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rot(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rotate_out == 2'b00 && k < 60);
    endtask

    initial begin
        int k, b_cw, b_ccw;
        wait_n(3);
        chk("reset_rotate", int'(rotate_out), 0);
        chk("reset_pressed", int'(pressed_out), 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        wait_n(2);

        // clean cw press: latency, single pulse, release latency
        b_cw = n_cw; b_ccw = n_ccw;
        cw = 1'b1;
        wait_rot(k);
        chk("cw_latency", k, D + 3);
        chk("cw_code", int'(rotate_out), 1);
        wait_n(1);
        chk("cw_pressed", int'(pressed_out), 1);
        cw = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (pressed_out != 2'b00 && k < 60);
        chk("release_latency", k, D + 3);
        wait_n(5);
        chk("cw_pulse_count", n_cw - b_cw, 1);
        chk("cw_no_ccw", n_ccw - b_ccw, 0);

        // ccw bounce shorter than the debounce window
        b_ccw = n_ccw; any_prs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ccw = ~ccw;
            wait_n(2);
        end
        ccw = 1'b0;
        wait_n(15);
        chk("bounce_pulses", n_ccw - b_ccw, 0);
        chk("bounce_pressed", int'(any_prs), 0);

        // simultaneous press: nothing until ccw re-pressed alone
        b_cw = n_cw; b_ccw = n_ccw;
        cw = 1'b1; ccw = 1'b1;
        wait_n(20);
        chk("both_pulses", (n_cw - b_cw) + (n_ccw - b_ccw), 0);
        cw = 1'b0;
        wait_n(15);
        chk("both_cw_rel_pulses", (n_cw - b_cw) + (n_ccw - b_ccw), 0);
        ccw = 1'b0;
        wait_n(15);
        ccw = 1'b1;
        wait_n(12);
        chk("ccw_repress_pulse", n_ccw - b_ccw, 1);
        chk("ccw_repress_no_cw", n_cw - b_cw, 0);
        ccw = 1'b0;
        wait_n(15);

        // ownership: cw first, ccw ignored even after cw release
        b_cw = n_cw; b_ccw = n_ccw;
        cw = 1'b1;
        wait_n(5);
        ccw = 1'b1;
        wait_n(12);
        cw = 1'b0;
        wait_n(15);
        chk("own_cw_pulses", n_cw - b_cw, 1);
        chk("own_ccw_pulses", n_ccw - b_ccw, 0);
        ccw = 1'b0;
        wait_n(15);

        // 30-cycle hold: repeats only when the feature is built in
        b_cw = n_cw;
        cw = 1'b1;
        wait_n(30);
        cw = 1'b0;
        wait_n(15);
`ifdef ROTATE_AUTOREPEAT_EN
        chk("hold30_pulses", n_cw - b_cw, 8);
`else
        chk("hold30_pulses", n_cw - b_cw, 1);
`endif

        // reset mid-hold: outputs clear, held button re-debounced as a new press
        cw = 1'b1;
        wait_n(20);
        rst = 1'b1;
        wait_n(1);
        chk("rst_rotate", int'(rotate_out), 0);
        chk("rst_pressed", int'(pressed_out), 0);
        rst = 1'b0;
        wait_rot(k);
        chk("rst_relatency", k, D + 3);
        chk("rst_code", int'(rotate_out), 1);
        cw = 1'b0;
        wait_n(15);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotate_input.md
ROTATE_INPUT -- requirements
Module: rotate_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 371250, consecutive stable cycles (5 ms at 74.25 MHz) before a button level is accepted; legal range 1..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 29700000, cycles from first pulse to first auto-repeat pulse; legal range 1..2^26-1.
REQ-003 Parameter REPEAT_PERIOD, default 11137500, cycles between subsequent auto-repeat pulses; legal range 1..2^26-1.
REQ-004 clk  input  1  system clock, all logic on posedge.
REQ-005 rst  input  1  reset rst, synchronous, active-high.
REQ-006 btn_cw_in  input  1  raw clockwise button, asynchronous to clk, may bounce.
REQ-007 btn_ccw_in  input  1  raw counter-clockwise button, asynchronous to clk, may bounce.
REQ-008 rotate_out  output  2  one-cycle rotate command to game state: 2'b00 none, 2'b01 clockwise, 2'b10 counter-clockwise; 2'b11 SHALL never be driven.
REQ-009 pressed_out  output  2  debounced levels, bit0 = cw, bit1 = ccw.

Function
REQ-010 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-011 Per button, a counter SHALL count consecutive cycles where the synchronized level differs from the debounced level; reset to 0 whenever they agree.
REQ-012 Debounced level SHALL toggle at the edge where the counter reaches DEBOUNCE_CYCLES; counter returns to 0 on that edge.
REQ-013 Owner FSM states: IDLE, HELD_CW, HELD_CCW.
REQ-014 IDLE -> HELD_CW on debounced cw rise with ccw debounced low; emit rotate_out=2'b01 for exactly the following cycle.
REQ-015 IDLE -> HELD_CCW on debounced ccw rise with cw debounced low; emit 2'b10 for exactly the following cycle.
REQ-016 Both debounced levels rising on the same edge SHALL emit nothing and stay IDLE until both are low again.
REQ-017 In HELD_x, the other button rising SHALL be ignored (first press owns); no pulse for it.
REQ-018 HELD_x -> IDLE when owner debounced level falls; no pulse on release; if other button still held, it SHALL NOT pulse until re-pressed.
REQ-019 End-to-end latency: clean raw rise at edge t SHALL produce rotate_out nonzero in the cycle after edge t+DEBOUNCE_CYCLES+2 (DEBOUNCE_CYCLES+3 edges).
REQ-020 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no pressed_out change.
REQ-021 rotate_out SHALL be registered; never nonzero on two consecutive cycles.

Reset
REQ-022 On rst: synchronizers, debounced levels, counters to 0; FSM IDLE; rotate_out=2'b00; pressed_out=2'b00.
REQ-023 rst asserted mid-hold SHALL cancel any pending repeat; a button still held after rst release SHALL be re-debounced and pulse once as a new press.

Configuration
REQ-024 Macro ROTATE_AUTOREPEAT_EN: when defined, a repeat counter in HELD_x SHALL emit the owner code REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles while held; counter clears on leaving HELD_x.
REQ-025 Without ROTATE_AUTOREPEAT_EN: exactly one pulse per press, no repeat counter instantiated; REPEAT_DELAY/REPEAT_PERIOD unused.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Clean cw press at edge 0, held 8 cycles -> rotate_out=2'b01 exactly one cycle, after edge 7; pressed_out=2'b01; release -> no pulse, pressed_out=2'b00 after 7 edges.
REQ-027 ccw toggling every 2 cycles for 20 cycles then low -> rotate_out stays 2'b00, pressed_out stays 2'b00.
REQ-028 Both buttons rise on same edge, held 20 cycles -> no pulse; then cw released, ccw held -> still no pulse until ccw released and re-pressed.
REQ-029 cw held, ccw pressed 5 cycles later -> only 2'b01 pulses; cw released with ccw held -> no 2'b10 pulse.
REQ-030 With ROTATE_AUTOREPEAT_EN, cw held 30 cycles -> pulses at first pulse cycle P, P+10, P+13, P+16, ... until release; without macro -> only at P.
REQ-031 rst pulsed for 1 cycle during repeat hold -> outputs 2'b00 next cycle, next pulse exactly DEBOUNCE_CYCLES+3 edges after rst deasserts.
